// File: rtl/mandelbrot_scan_engine.sv
// Mandelbrot scan engine: walks a COLS x ROWS grid of points c and iterates
// z = z^2 + c per point, emitting (x, y, escape count) on a valid/ready stream.
// Latency per pixel with ready held high: 1 (INIT) + (n+1) (ITER) + 1 (HOLD).
// Backpressure: result_valid and its data stay stable in HOLD until result_ready.
// Ports: clk/rst_n; start/abort control; max_ctr, scaling, cr_offset, ci_offset
// configuration (latched on start); result_* stream; running/finished status.
module mandelbrot_scan_engine #(
  parameter int BITWIDTH  = 11,
  parameter int FRAC      = BITWIDTH - 3,
  parameter int CTRWIDTH  = 7,
  parameter int SCALEBITS = 2,
  parameter int COLS      = 16,
  parameter int ROWS      = 16,
  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CTRWIDTH-1:0]  max_ctr,
  input  logic [SCALEBITS-1:0] scaling,
  input  logic [BITWIDTH-1:0]  cr_offset,
  input  logic [BITWIDTH-1:0]  ci_offset,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [CTRWIDTH-1:0]  result_ctr,
  output logic [XW-1:0]        result_x,
  output logic [YW-1:0]        result_y,
  output logic                 running,
  output logic                 finished
);

  // Full-precision width for squares and their sum.
  localparam int PW = 2 * BITWIDTH + 1;
  localparam logic signed [PW-1:0] FOUR = PW'(64'sd1 <<< (2 * FRAC + 2));
  localparam logic signed [PW-1:0] MAXV = PW'((64'sd1 <<< (BITWIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] MINV = PW'(-(64'sd1 <<< (BITWIDTH - 1)));

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_ITER, S_HOLD, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CTRWIDTH-1:0]        max_q, ctr;
  logic [SCALEBITS-1:0]       scl_q;
  logic [BITWIDTH-1:0]        cro_q, cio_q;
  logic signed [BITWIDTH-1:0] cr, ci, zr, zi;
  logic [XW-1:0]              x;
  logic [YW-1:0]              y;

  logic signed [PW-1:0] zr_ext, zi_ext, cr_ext, ci_ext;
  logic signed [PW-1:0] zr2, zi2, zrzi2, mag, re_full, im_full;
  logic [BITWIDTH-1:0]  x_step, y_step;
  logic                 escaped, stop, last_col, last_row;

  function automatic logic signed [BITWIDTH-1:0] sat(input logic signed [PW-1:0] v);
    if (v > MAXV)      return {1'b0, {(BITWIDTH-1){1'b1}}};
    else if (v < MINV) return {1'b1, {(BITWIDTH-1){1'b0}}};
    else               return v[BITWIDTH-1:0];
  endfunction

  // Iteration datapath. The difference of squares and the cross term are
  // formed at full width, floored by FRAC, c added, and only then clamped.
  always_comb begin
    zr_ext  = {{(PW-BITWIDTH){zr[BITWIDTH-1]}}, zr};
    zi_ext  = {{(PW-BITWIDTH){zi[BITWIDTH-1]}}, zi};
    cr_ext  = {{(PW-BITWIDTH){cr[BITWIDTH-1]}}, cr};
    ci_ext  = {{(PW-BITWIDTH){ci[BITWIDTH-1]}}, ci};
    zr2     = zr_ext * zr_ext;
    zi2     = zi_ext * zi_ext;
    zrzi2   = (zr_ext * zi_ext) <<< 1;
    mag     = zr2 + zi2;
    re_full = ((zr2 - zi2) >>> FRAC) + cr_ext;
    im_full = (zrzi2 >>> FRAC) + ci_ext;
    escaped = (mag >= FOUR);
    stop    = escaped || (ctr == max_q);
    // Pixel step is a power of two, so x*step is a shift; wraps mod 2^BITWIDTH.
    x_step  = BITWIDTH'(x) << scl_q;
    y_step  = BITWIDTH'(y) << scl_q;
    last_col = (x == XW'(COLS - 1));
    last_row = (y == YW'(ROWS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_INIT;
      S_INIT:         state_nxt = S_ITER;
      S_ITER:         if (stop) state_nxt = S_HOLD;
      S_HOLD:         if (result_ready) state_nxt = (last_col && last_row) ? S_DONE : S_INIT;
      default:        state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q      <= '0;
      scl_q      <= '0;
      cro_q      <= '0;
      cio_q      <= '0;
      cr         <= '0;
      ci         <= '0;
      zr         <= '0;
      zi         <= '0;
      ctr        <= '0;
      x          <= '0;
      y          <= '0;
      result_ctr <= '0;
    end else if (!abort) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            max_q <= max_ctr;
            scl_q <= scaling;
            cro_q <= cr_offset;
            cio_q <= ci_offset;
            x     <= '0;
            y     <= '0;
          end
        end
        S_INIT: begin
          cr  <= cro_q + x_step;
          ci  <= cio_q + y_step;
          zr  <= '0;
          zi  <= '0;
          ctr <= '0;
        end
        S_ITER: begin
          if (stop) begin
            result_ctr <= ctr;
          end else begin
            zr  <= sat(re_full);
            zi  <= sat(im_full);
            ctr <= ctr + CTRWIDTH'(1);
          end
        end
        S_HOLD: begin
          // The final pixel leaves x/y in place; DONE does not advance.
          if (result_ready && !(last_col && last_row)) begin
            if (last_col) begin
              x <= '0;
              y <= y + YW'(1);
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign result_valid = (state == S_HOLD);
  assign result_x     = x;
  assign result_y     = y;
  assign running      = (state == S_INIT) || (state == S_ITER) || (state == S_HOLD);
  assign finished     = (state == S_DONE);

endmodule

// File: tb/tb_mandelbrot_scan_engine.sv
// Directed bench for mandelbrot_scan_engine: three instances (1x1, 2x2, 4x4
// grids) share all inputs; one is selected for checking at a time.
module tb_mandelbrot_scan_engine;

  localparam int BW = 11;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, ready;
  logic [CW-1:0] max_ctr;
  logic [1:0]    scaling;
  logic [BW-1:0] cr_offset, ci_offset;

  logic v1, r1, f1, v2, r2, f2, v4, r4, f4;
  logic [CW-1:0] c1, c2, c4;
  logic x1, y1, x2, y2;
  logic [1:0] x4, y4;

  mandelbrot_scan_engine #(.BITWIDTH(BW), .CTRWIDTH(CW), .COLS(1), .ROWS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .max_ctr(max_ctr),
    .scaling(scaling), .cr_offset(cr_offset), .ci_offset(ci_offset),
    .result_valid(v1), .result_ready(ready), .result_ctr(c1), .result_x(x1),
    .result_y(y1), .running(r1), .finished(f1));

  mandelbrot_scan_engine #(.BITWIDTH(BW), .CTRWIDTH(CW), .COLS(2), .ROWS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .max_ctr(max_ctr),
    .scaling(scaling), .cr_offset(cr_offset), .ci_offset(ci_offset),
    .result_valid(v2), .result_ready(ready), .result_ctr(c2), .result_x(x2),
    .result_y(y2), .running(r2), .finished(f2));

  mandelbrot_scan_engine #(.BITWIDTH(BW), .CTRWIDTH(CW), .COLS(4), .ROWS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .max_ctr(max_ctr),
    .scaling(scaling), .cr_offset(cr_offset), .ci_offset(ci_offset),
    .result_valid(v4), .result_ready(ready), .result_ctr(c4), .result_x(x4),
    .result_y(y4), .running(r4), .finished(f4));

  always #5 clk = ~clk;

  int sel = 1;
  logic cur_valid, cur_running, cur_finished;
  int   cur_x, cur_y, cur_ctr;

  always_comb begin
    cur_valid = 1'b0; cur_running = 1'b0; cur_finished = 1'b0;
    cur_x = 0; cur_y = 0; cur_ctr = 0;
    case (sel)
      1: begin cur_valid = v1; cur_running = r1; cur_finished = f1;
               cur_x = int'(x1); cur_y = int'(y1); cur_ctr = int'(c1); end
      2: begin cur_valid = v2; cur_running = r2; cur_finished = f2;
               cur_x = int'(x2); cur_y = int'(y2); cur_ctr = int'(c2); end
      4: begin cur_valid = v4; cur_running = r4; cur_finished = f4;
               cur_x = int'(x4); cur_y = int'(y4); cur_ctr = int'(c4); end
      default: ;
    endcase
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Abort everything, then start a frame with the given configuration.
  // Afterwards the inputs are scrambled to confirm the frame uses latched values.
  // Returns at the falling edge right after the start edge.
  task automatic begin_frame(input int cr, input int ci, input int mx, input int scl);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    cr_offset = BW'(cr); ci_offset = BW'(ci); max_ctr = CW'(mx); scaling = 2'(scl);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    cr_offset = 11'h155; ci_offset = 11'h0AA; max_ctr = 7'd3; scaling = 2'd2;
  endtask

  // Waits for an accepted result; lat counts cycles from the previous
  // start/accept edge to this accept edge. Returns on the falling edge after it.
  task automatic get_result(output int rx, output int ry, output int rc, output int lat);
    int k = 0;
    while (!(cur_valid && ready) && k < 300) begin
      @(negedge clk); k++;
    end
    if (k >= 300) begin
      checks++; failures++;
      $display("FAIL result_timeout actual=%0d required=<300", k);
      rx = -1; ry = -1; rc = -1; lat = -1;
    end else begin
      rx = cur_x; ry = cur_y; rc = cur_ctr; lat = k + 1;
      @(negedge clk);
    end
  endtask

  typedef struct {
    int cr; int ci; int mx; int exp_ctr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int rx, ry, rc, lat, k;
    int e2x[4], e2y[4], e2c[4];

    vecs[0] = '{0,    0,   20, 20};  // c=0 never escapes
    vecs[1] = '{512,  0,   20, 1};   // 2.0: |z1|^2 == 4 escapes
    vecs[2] = '{256,  0,   20, 2};   // 1.0: z=1, then 2
    vecs[3] = '{-512, 0,   20, 1};   // -2.0 on the >= boundary
    vecs[4] = '{0,    512, 20, 1};   // 2i
    vecs[5] = '{0,    0,   5,  5};
    vecs[6] = '{-256, 0,   7,  7};   // -1.0 cycles 0,-1,0,-1
    e2x = '{0, 1, 0, 1}; e2y = '{0, 0, 1, 1}; e2c = '{2, 2, 3, 2};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
    max_ctr = '0; scaling = '0; cr_offset = '0; ci_offset = '0;
    #3;
    check("rst_valid", int'(v1 | v2 | v4), 0);
    check("rst_running", int'(r1 | r2 | r4), 0);
    check("rst_finished", int'(f1 | f2 | f4), 0);
    check("rst_ctr", int'(c1 | c2 | c4), 0);
    check("rst_xy", int'(x1) + int'(y1) + int'(x2) + int'(y2) + int'(x4) + int'(y4), 0);
    @(negedge clk); rst_n = 1'b1;

    // Single-point vectors on the 1x1 grid.
    sel = 1;
    for (int i = 0; i < 7; i++) begin
      begin_frame(vecs[i].cr, vecs[i].ci, vecs[i].mx, 0);
      get_result(rx, ry, rc, lat);
      check($sformatf("v%0d_ctr", i), rc, vecs[i].exp_ctr);
      check($sformatf("v%0d_xy", i), rx + ry, 0);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_ctr + 3);
      check($sformatf("v%0d_finished", i), int'(cur_finished), 1);
      check($sformatf("v%0d_running", i), int'(cur_running), 0);
      check($sformatf("v%0d_valid_low", i), int'(cur_valid), 0);
    end

    // 2x2 raster with scaling=1; start is held high to show it is ignored mid-frame.
    sel = 2;
    begin_frame(256, 0, 20, 1);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      get_result(rx, ry, rc, lat);
      check($sformatf("g2_%0d_x", i), rx, e2x[i]);
      check($sformatf("g2_%0d_y", i), ry, e2y[i]);
      check($sformatf("g2_%0d_ctr", i), rc, e2c[i]);
      check($sformatf("g2_%0d_latency", i), lat, e2c[i] + 3);
    end
    check("g2_finished", int'(cur_finished), 1);
    start = 1'b0;

    // 4x4 with max_ctr=0: every pixel takes 3 cycles.
    sel = 4;
    begin_frame(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      get_result(rx, ry, rc, lat);
      check($sformatf("g4_%0d_x", i), rx, i % 4);
      check($sformatf("g4_%0d_y", i), ry, i / 4);
      check($sformatf("g4_%0d_ctr", i), rc, 0);
      check($sformatf("g4_%0d_latency", i), lat, 3);
    end
    check("g4_finished", int'(cur_finished), 1);

    // Backpressure: hold ready low for 10 cycles in HOLD.
    sel = 2; ready = 1'b0;
    begin_frame(256, 0, 20, 1);
    k = 0;
    while (!cur_valid && k < 100) begin @(negedge clk); k++; end
    check("bp_valid_seen", int'(cur_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_valid", i), int'(cur_valid), 1);
      check($sformatf("bp_hold%0d_data", i), cur_x * 1000 + cur_y * 100 + cur_ctr, 2);
    end
    ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", int'(cur_valid), 0);
    check("bp_x_advanced", cur_x, 1);
    get_result(rx, ry, rc, lat);
    check("bp_next_pixel", rx * 10 + ry, 10);

    // Abort during ITER.
    sel = 1;
    begin_frame(0, 0, 20, 0);
    repeat (5) @(negedge clk);
    check("ab_iter_running_before", int'(cur_running), 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("ab_iter_running", int'(cur_running), 0);
    check("ab_iter_valid", int'(cur_valid), 0);
    check("ab_iter_finished", int'(cur_finished), 0);
    repeat (3) @(negedge clk);
    check("ab_iter_stays_idle", int'(cur_running | cur_finished), 0);

    // Abort during HOLD.
    ready = 1'b0;
    begin_frame(512, 0, 20, 0);
    k = 0;
    while (!cur_valid && k < 100) begin @(negedge clk); k++; end
    check("ab_hold_valid_seen", int'(cur_valid), 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("ab_hold_valid", int'(cur_valid), 0);
    check("ab_hold_running", int'(cur_running), 0);
    check("ab_hold_finished", int'(cur_finished), 0);
    ready = 1'b1;

    // Asynchronous reset mid-frame, after the first 2x2 pixel has advanced x.
    sel = 2;
    begin_frame(256, 0, 20, 1);
    get_result(rx, ry, rc, lat);
    check("rs_pre_x", cur_x, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_valid", int'(cur_valid), 0);
    check("rs_running", int'(cur_running), 0);
    check("rs_finished", int'(cur_finished), 0);
    check("rs_x", cur_x, 0);
    check("rs_ctr", cur_ctr, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rs_idle_after", int'(cur_running), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
